// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and the MEM-stage data requester.
// Latency: request sampled in IDLE at N, mem_req_o at N+1, rvalid pulse at N+3 minimum.
// Backpressure: requesters hold req until their 1-cycle gnt pulse; one outstanding transaction.
//
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   if_req_i/if_addr_i -> if_gnt_o/if_rvalid_o/if_rdata_o           fetch requester
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i -> d_gnt_o/d_rvalid_o/d_rdata_o  data requester
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o, mem_gnt_i/mem_rvalid_i/mem_rdata_i  memory port
//   busy_o (not IDLE), err_o (response timeout pulse)
// Optional feature macro: MEM_ARB_RR_EN (round-robin between requesters when both pend).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state;
  logic                owner_d;    // 1 = data requester owns the transaction
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_rvalid_q;
  logic                d_rvalid_q;
  logic                err_q;
  logic                sel_data;

`ifdef MEM_ARB_RR_EN
  logic last_owner_d;  // 0 = fetch was served last (reset value)
  // When both pend, serve whoever was not served last.
  assign sel_data = d_req_i && (!if_req_i || !last_owner_d);
`else
  assign sel_data = d_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt         <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_d <= 1'b0;
`endif
    end else begin
      // Response/error flags are single-cycle: set on entry to DONE only.
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req_i || d_req_i) begin
            owner_d <= sel_data;
            if (sel_data) begin
              we_q    <= d_we_i;
              addr_q  <= d_addr_i;
              wdata_q <= d_wdata_i;
              be_q    <= d_be_i;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= if_addr_i;
              wdata_q <= '0;
              be_q    <= '1;
            end
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            cnt   <= '0;
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            if (owner_d) d_rdata_q  <= mem_rdata_i;
            else         if_rdata_q <= mem_rdata_i;
            d_rvalid_q  <= owner_d;
            if_rvalid_q <= !owner_d;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            // Abort: owner still gets its response pulse, with zero data.
            if (owner_d) d_rdata_q  <= '0;
            else         if_rdata_q <= '0;
            d_rvalid_q  <= owner_d;
            if_rvalid_q <= !owner_d;
            err_q       <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
`ifdef MEM_ARB_RR_EN
          last_owner_d <= owner_d;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant is passed through in the same cycle the memory accepts.
  assign if_gnt_o    = (state == REQ) && mem_gnt_i && !owner_d;
  assign d_gnt_o     = (state == REQ) && mem_gnt_i && owner_d;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;
  assign busy_o      = (state != IDLE);
  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule
